// File: rtl/seven_seg_scan_controller.sv
// Three-digit seven-segment scan controller: steps through D1..D3 slots, blanks the
// start of each slot, and shows hex values latched once per frame so digits never tear.
module seven_seg_scan_controller #(
  parameter int DIV   = 1000,
  parameter int BLANK = 100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_val0,
  input  logic [3:0] i_val1,
  input  logic [3:0] i_val2,
  input  logic [2:0] i_dp,
  output logic [1:0] o_sel,
  output logic [2:0] o_dig,
  output logic [6:0] o_seg,
  output logic       o_dot,
  output logic       o_frame
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  localparam logic [1:0] SEL_D1 = 2'b00;
  localparam logic [1:0] SEL_D2 = 2'b01;
  localparam logic [1:0] SEL_D3 = 2'b10;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [3:0]    r_s0, r_s1, r_s2;
  logic [2:0]    r_sdp;
  logic          r_frame;

  logic          w_past_blank;
  logic          w_lit;
  logic [3:0]    w_val;
  logic          w_dp;
  logic [6:0]    w_hex;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_sel   <= SEL_D1;
      r_s0    <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_sdp   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (i_en) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt <= '0;
          // The D3->D1 wrap is the only point where new values become visible.
          if (r_sel == SEL_D3) begin
            r_sel   <= SEL_D1;
            r_s0    <= i_val0;
            r_s1    <= i_val1;
            r_s2    <= i_val2;
            r_sdp   <= i_dp;
            r_frame <= 1'b1;
          end else begin
            r_sel <= r_sel + 2'd1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  generate
    if (BLANK == 0) begin : g_no_blank
      assign w_past_blank = 1'b1;
    end else begin : g_blank
      assign w_past_blank = (r_cnt >= CNT_BLANK);
    end
  endgenerate

  assign w_lit = i_en & w_past_blank;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dig
      assign o_dig[2-gi] = w_lit && (r_sel == 2'(gi));
    end
  endgenerate

  always_comb begin
    w_val = r_s0;
    w_dp  = r_sdp[2];
    case (r_sel)
      SEL_D2: begin
        w_val = r_s1;
        w_dp  = r_sdp[1];
      end
      SEL_D3: begin
        w_val = r_s2;
        w_dp  = r_sdp[0];
      end
      default: ;
    endcase
  end

  // Segment order is g..a, active-high.
  always_comb begin
    w_hex = 7'h00;
    case (w_val)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      4'hF: w_hex = 7'h71;
      default: w_hex = 7'h00;
    endcase
  end

  assign o_sel   = r_sel;
  assign o_seg   = w_lit ? w_hex : 7'h00;
  assign o_dot   = w_lit & w_dp;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Scoreboard bench: two scan controllers (BLANK=1 and BLANK=0, DIV=4) driven together,
// checked each cycle against a tick-count reference model.
module tb_seven_seg_scan_controller;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME_LEN = 3 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] val0 = '0, val1 = '0, val2 = '0;
  logic [2:0] dp  = '0;

  logic [1:0] a_sel, b_sel;
  logic [2:0] a_dig, b_dig;
  logic [6:0] a_seg, b_seg;
  logic       a_dot, b_dot, a_frame, b_frame;

  always #5 clk = ~clk;

  seven_seg_scan_controller #(.DIV(DIV), .BLANK(BLANK)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_val0(val0), .i_val1(val1), .i_val2(val2), .i_dp(dp),
    .o_sel(a_sel), .o_dig(a_dig), .o_seg(a_seg), .o_dot(a_dot), .o_frame(a_frame)
  );

  seven_seg_scan_controller #(.DIV(DIV), .BLANK(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_val0(val0), .i_val1(val1), .i_val2(val2), .i_dp(dp),
    .o_sel(b_sel), .o_dig(b_dig), .o_seg(b_seg), .o_dot(b_dot), .o_frame(b_frame)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] dig_a;
    logic [6:0] seg_a;
    logic       dot_a;
    logic [2:0] dig_b;
    logic [6:0] seg_b;
    logic       dot_b;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: enabled ticks into the current frame, plus the latched frame values.
  int         t = 0;
  logic [3:0] snap [3];
  logic [2:0] sdp = '0;
  logic       frm = 1'b0;

  task automatic model_edge();
    if (rst) begin
      t = 0;
      snap[0] = '0; snap[1] = '0; snap[2] = '0;
      sdp = '0;
      frm = 1'b0;
    end else if (en) begin
      t = t + 1;
      if (t == FRAME_LEN) begin
        t = 0;
        snap[0] = val0; snap[1] = val1; snap[2] = val2;
        sdp = dp;
        frm = 1'b1;
      end else begin
        frm = 1'b0;
      end
    end else begin
      frm = 1'b0;
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int   slot, pos;
    logic lit_a, lit_b;
    slot  = t / DIV;
    pos   = t % DIV;
    lit_a = en && (pos >= BLANK);
    lit_b = en;
    e.sel   = 2'(slot);
    e.frame = frm;
    e.dig_a = lit_a ? (3'b100 >> slot) : 3'b000;
    e.seg_a = lit_a ? hex_tab[snap[slot]] : 7'h00;
    e.dot_a = lit_a ? sdp[2 - slot] : 1'b0;
    e.dig_b = lit_b ? (3'b100 >> slot) : 3'b000;
    e.seg_b = lit_b ? hex_tab[snap[slot]] : 7'h00;
    e.dot_b = lit_b ? sdp[2 - slot] : 1'b0;
    return e;
  endfunction

  // One cycle: advance model across the edge, then apply the inputs for this cycle.
  task automatic step(input logic r, input logic e, input logic [3:0] v0, input logic [3:0] v1,
                      input logic [3:0] v2, input logic [2:0] d);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; en = e; val0 = v0; val1 = v1; val2 = v2; dp = d;
    q.push_back(expect_now());
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (a_sel !== e.sel || a_dig !== e.dig_a || a_seg !== e.seg_a || a_dot !== e.dot_a ||
          a_frame !== e.frame || b_sel !== e.sel || b_dig !== e.dig_b || b_seg !== e.seg_b ||
          b_dot !== e.dot_b || b_frame !== e.frame) begin
        miscompares++;
        $display("FAIL scan v%0d: A sel=%b dig=%b seg=%h dot=%b frm=%b B sel=%b dig=%b seg=%h dot=%b frm=%b | want sel=%b digA=%b segA=%h dotA=%b digB=%b segB=%h dotB=%b frm=%b",
                 vectors, a_sel, a_dig, a_seg, a_dot, a_frame, b_sel, b_dig, b_seg, b_dot, b_frame,
                 e.sel, e.dig_a, e.seg_a, e.dot_a, e.dig_b, e.seg_b, e.dot_b, e.frame);
      end else begin
        $display("ok v%0d: sel=%b digA=%b segA=%h dotA=%b digB=%b frame=%b",
                 vectors, a_sel, a_dig, a_seg, a_dot, b_dig, a_frame);
      end
    end
  end

  initial begin
    int guard;
    snap[0] = '0; snap[1] = '0; snap[2] = '0;

    // Reset held three cycles, then idle with EN low.
    repeat (3) step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000);
    repeat (10) step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000);

    // Reset straight into a basic scan; VAL1 changes mid-D1 slot of the second frame.
    step(1'b1, 1'b0, 4'h1, 4'h2, 4'h3, 3'b010);
    for (int c = 0; c < 40; c++)
      step(1'b0, 1'b1, 4'h1, (c >= 14) ? 4'hF : 4'h2, 4'h3, 3'b010);

    // Enable pause in the D2 slot.
    guard = 0;
    while (!(t == DIV + 1) && guard < 50) begin
      step(1'b0, 1'b1, 4'h1, 4'hF, 4'h3, 3'b010);
      guard++;
    end
    repeat (5) step(1'b0, 1'b0, 4'h1, 4'hF, 4'h3, 3'b010);
    repeat (10) step(1'b0, 1'b1, 4'h1, 4'hF, 4'h3, 3'b010);

    // Reset asserted while the last D3 cycle is showing.
    guard = 0;
    while (!(t == FRAME_LEN - 2) && guard < 50) begin
      step(1'b0, 1'b1, 4'h7, 4'h8, 4'h9, 3'b101);
      guard++;
    end
    step(1'b1, 1'b1, 4'h7, 4'h8, 4'h9, 3'b101);
    repeat (30) step(1'b0, 1'b1, 4'h7, 4'h8, 4'h9, 3'b101);

    // Decode sweep: one VAL0 per frame covers every table entry.
    for (int v = 0; v < 16; v++)
      repeat (FRAME_LEN) step(1'b0, 1'b1, 4'(v), 4'(15 - v), 4'(v ^ 5), 3'(v));
    repeat (FRAME_LEN) step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 3'b000);

    // Randomized traffic: mostly enabled, occasional reset, values churning every cycle.
    for (int c = 0; c < 800; c++)
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_controller.md
# seven_seg_scan_controller

Time-multiplexing controller for the 3-digit seven-segment display. It steps the 2-bit digit select through 00→01→10 at a programmable rate and drives the one-hot digit enables with a blanking gap at the start of each slot to prevent ghosting. It also decodes the selected digit's hex value to segments. Per-frame snapshot registers keep a digit from changing mid-frame. It sits between the value-producing logic and the display pins; its SEL output uses the same 00/01/10 → D1/D2/D3 encoding as the existing digit switcher.

## Interface
- DIV, 1000: clock cycles per digit slot; legal range DIV ≥ 2.
- BLANK, 100: cycles at the start of each slot with all digits off; legal range 0 ≤ BLANK < DIV.
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- EN  input  1  scan enable; sampled each cycle.
- VAL0, VAL1, VAL2  input  4 each  hex values for digit D1, D2, D3.
- DP  input  3  decimal points; DP[2]→D1, DP[1]→D2, DP[0]→D3.
- SEL  output  2  current slot: 00=D1, 01=D2, 10=D3. 11 never occurs.
- DIG  output  3  digit enables {D1,D2,D3}, one-hot or all-zero, active-high.
- SEG  output  7  segments g..a (SEG[6]=g, SEG[0]=a), active-high.
- DOT  output  1  decimal point of the current digit, active-high.
- FRAME  output  1  one-cycle pulse marking the start of a new frame.

## Operation
- State registers:
  - CNT, width clog2(DIV), counts 0..DIV-1.
  - SEL.
  - Snapshot registers S0, S1, S2 (4 bits each) and SDP (3 bits).
  - FRAME register.
- RST=1 on a clock edge clears all of them to 0. The first frame after reset therefore displays 0 with all points off.
- When EN=1:
  - CNT increments each cycle.
  - When CNT=DIV-1, CNT wraps to 0 and SEL advances 00→01→10→00.
  - On the 10→00 wrap only, S0..S2 and SDP load VAL0..2 and DP, and FRAME is set to 1 for the next cycle.
- When EN=0: CNT, SEL and the snapshots hold, and FRAME is 0.
- Outputs are combinational from registered state:
  - DIG is one-hot for SEL when EN=1 and CNT ≥ BLANK; otherwise 000.
  - SEG is the hex decode of the selected snapshot when DIG≠000; otherwise 0000000.
  - DOT is the SDP bit of the selected digit when DIG≠000; otherwise 0.
- Hex decode (SEG as hex, g..a):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Changes to VALx/DP mid-frame have no visible effect until the next 10→00 wrap.

## Timing
- Reset values: SEL=00, DIG=000 (when BLANK ≥ 1), SEG=0000000, DOT=0, FRAME=0.
  - With BLANK=0 and EN=1, DIG=100 on the cycle after reset.
- Slot length is DIV cycles. The first BLANK cycles of each slot are dark. Frame length is 3·DIV cycles.
- FRAME is high for exactly one cycle: the first cycle with SEL=00 and CNT=0 following a wrap. The new snapshot is visible in that same cycle. FRAME does not assert on reset release.
- EN falling mid-slot: DIG goes 000 in the same cycle (combinational). Counting resumes from the held CNT/SEL when EN returns.
- EN=0 on the wrap cycle: no wrap occurs, and the snapshot and FRAME wait until EN=1 at CNT=DIV-1.
- RST has priority over EN. RST mid-slot returns to SEL=00, CNT=0 on the next edge and clears the snapshots.
- Invariant: SEL never equals 11, and DIG never has more than one bit set.

## Test plan
All scenarios use DIV=4, BLANK=1.

- **Reset/idle:** hold RST=1 for 3 cycles, then EN=0 → SEL=00, DIG=000, SEG=00, DOT=0, FRAME=0, all held indefinitely.
- **Basic scan:** VAL0=1, VAL1=2, VAL2=3, DP=010, EN=1 from reset.
  - First frame: D1 slot shows SEG=3F (zero snapshot).
  - After the first FRAME pulse (cycle 12), the D1 slot pattern is DIG=000,100,100,100 with SEG=06.
  - The D2 slot has SEG=5B with DOT=1.
  - The D3 slot has SEG=4F.
- **Tearing guard:** change VAL1 from 2 to F at cycle 14 (mid-D1 slot) → the D2 slot in that frame still shows 5B; the next frame shows 71.
- **Enable pause:** drop EN at SEL=01, CNT=2 for 5 cycles → DIG=000 immediately, SEL/CNT hold. On EN=1, CNT continues at 2→3, then SEL=10.
- **Mid-frame reset:** assert RST at SEL=10, CNT=3 → next cycle SEL=00, CNT=0, snapshots 0, no FRAME pulse. Scan restarts cleanly with period 12.
- **Decode sweep with BLANK=0:** cycle VAL0 through 0..F, one per frame → SEG matches all 16 table entries, and DIG=100 for the entire D1 slot.
